// File: rtl/rvfi_pkg.sv
// Shared types and helpers for the RVFI retire serializer: packet payload layout and popcount.
package rvfi_pkg;

    localparam int unsigned RVFI_XLEN     = 32;
    localparam int unsigned RVFI_ORDER_W  = 64;
    localparam int unsigned RVFI_ILEN     = 32;
    localparam int unsigned RVFI_NRET_MAX = 4;
    localparam int unsigned RVFI_PC_W     = 3;

    typedef struct packed {
        logic [RVFI_ORDER_W-1:0] order;
        logic [RVFI_ILEN-1:0]    insn;
        logic                    trap;
        logic [RVFI_XLEN-1:0]    pc_rdata;
        logic [RVFI_XLEN-1:0]    pc_wdata;
        logic [4:0]              rd_addr;
        logic [RVFI_XLEN-1:0]    rd_wdata;
    } rvfi_pkt_t;

    // Number of set bits in a retire-valid vector (0..RVFI_NRET_MAX).
    function automatic logic [RVFI_PC_W-1:0] popcount(input logic [RVFI_NRET_MAX-1:0] v);
        logic [RVFI_PC_W-1:0] c;
        c = '0;
        for (int i = 0; i < int'(RVFI_NRET_MAX); i++) begin
            c = c + RVFI_PC_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/rvfi_pkt_ram.sv
// DEPTH-entry packet store with NRET independent write ports and one asynchronous read port.
module rvfi_pkt_ram
    import rvfi_pkg::*;
#(
    parameter int unsigned NRET  = 2,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic            clock,
    input  logic            we    [NRET],
    input  logic [AW-1:0]   waddr [NRET],
    input  rvfi_pkt_t       wdata [NRET],
    input  logic [AW-1:0]   raddr,
    output rvfi_pkt_t       rdata
);

    rvfi_pkt_t mem [DEPTH];

    // Contents are not reset; validity is tracked by the owner's count.
    always_ff @(posedge clock) begin
        for (int k = 0; k < int'(NRET); k++) begin
            if (we[k]) begin
                mem[waddr[k]] <= wdata[k];
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rvfi_retire_serializer.sv
// Buffers up to NRET RVFI retirements per cycle and replays them one per cycle,
// checking rvfi_order contiguity and flagging overflow.
module rvfi_retire_serializer
    import rvfi_pkg::*;
#(
    parameter int unsigned NRET    = 2,
    parameter int unsigned XLEN    = RVFI_XLEN,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned ORDER_W = RVFI_ORDER_W
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NRET-1:0]          in_valid,
    input  logic [NRET*ORDER_W-1:0]  in_order,
    input  logic [NRET*32-1:0]       in_insn,
    input  logic [NRET-1:0]          in_trap,
    input  logic [NRET*XLEN-1:0]     in_pc_rdata,
    input  logic [NRET*XLEN-1:0]     in_pc_wdata,
    input  logic [NRET*5-1:0]        in_rd_addr,
    input  logic [NRET*XLEN-1:0]     in_rd_wdata,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ORDER_W-1:0]       out_order,
    output logic [31:0]              out_insn,
    output logic                     out_trap,
    output logic [XLEN-1:0]          out_pc_rdata,
    output logic [XLEN-1:0]          out_pc_wdata,
    output logic [4:0]               out_rd_addr,
    output logic [XLEN-1:0]          out_rd_wdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err_order,
    output logic                     err_overflow,
    output logic [ORDER_W-1:0]       exp_order
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [AW-1:0]        wptr;
    logic [AW-1:0]        rptr;
    logic [RVFI_PC_W-1:0] n_acc;
    logic [RVFI_PC_W-1:0] slot;
    logic                 transfer;
    logic [CW-1:0]        count_next;

    logic                 we    [NRET];
    logic [AW-1:0]        waddr [NRET];
    rvfi_pkt_t            wdata [NRET];
    rvfi_pkt_t            head;
    rvfi_pkt_t            head_out;

    // Admission depends only on registered occupancy; dequeue this cycle earns no credit.
    assign in_ready = (CW'(DEPTH) - count) >= CW'(NRET);
    assign out_valid = (count != '0);
    assign transfer  = out_valid && out_ready;
    assign n_acc     = in_ready ? popcount(RVFI_NRET_MAX'(in_valid)) : '0;
    assign count_next = count + CW'(n_acc) - CW'(transfer);

    // Compact valid channels onto consecutive slots: channel k lands at wptr + (valid bits below k).
    always_comb begin
        slot = '0;
        for (int k = 0; k < int'(NRET); k++) begin
            we[k]             = in_ready && in_valid[k];
            waddr[k]          = wptr + AW'(slot);
            wdata[k].order    = in_order[k*ORDER_W +: ORDER_W];
            wdata[k].insn     = in_insn[k*32 +: 32];
            wdata[k].trap     = in_trap[k];
            wdata[k].pc_rdata = in_pc_rdata[k*XLEN +: XLEN];
            wdata[k].pc_wdata = in_pc_wdata[k*XLEN +: XLEN];
            wdata[k].rd_addr  = in_rd_addr[k*5 +: 5];
            wdata[k].rd_wdata = in_rd_wdata[k*XLEN +: XLEN];
            slot              = slot + RVFI_PC_W'(in_valid[k]);
        end
    end

    rvfi_pkt_ram #(
        .NRET  (NRET),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clock (clock),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (rptr),
        .rdata (head)
    );

    // Head fields read as zero whenever the queue is empty (including right after reset).
    assign head_out     = out_valid ? head : '0;
    assign out_order    = head_out.order;
    assign out_insn     = head_out.insn;
    assign out_trap     = head_out.trap;
    assign out_pc_rdata = head_out.pc_rdata;
    assign out_pc_wdata = head_out.pc_wdata;
    assign out_rd_addr  = head_out.rd_addr;
    assign out_rd_wdata = head_out.rd_wdata;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            err_order    <= 1'b0;
            err_overflow <= 1'b0;
            exp_order    <= '0;
        end else begin
            wptr  <= wptr + AW'(n_acc);
            rptr  <= rptr + AW'(transfer);
            count <= count_next;
            if (!in_ready && (in_valid != '0)) begin
                err_overflow <= 1'b1;
            end
            // Resynchronise to the observed order so one gap is reported once.
            if (transfer) begin
                if (head.order != exp_order) begin
                    err_order <= 1'b1;
                end
                exp_order <= head.order + ORDER_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rvfi_retire_serializer.sv
// Directed, table-driven bench for rvfi_retire_serializer (NRET=2, DEPTH=8).
module tb_rvfi_retire_serializer;

    localparam int unsigned NRET    = 2;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned ORDER_W = 64;

    logic                    clock;
    logic                    reset_n;
    logic [NRET-1:0]         in_valid;
    logic [NRET*ORDER_W-1:0] in_order;
    logic [NRET*32-1:0]      in_insn;
    logic [NRET-1:0]         in_trap;
    logic [NRET*XLEN-1:0]    in_pc_rdata;
    logic [NRET*XLEN-1:0]    in_pc_wdata;
    logic [NRET*5-1:0]       in_rd_addr;
    logic [NRET*XLEN-1:0]    in_rd_wdata;
    logic                    in_ready;
    logic                    out_valid;
    logic                    out_ready;
    logic [ORDER_W-1:0]      out_order;
    logic [31:0]             out_insn;
    logic                    out_trap;
    logic [XLEN-1:0]         out_pc_rdata;
    logic [XLEN-1:0]         out_pc_wdata;
    logic [4:0]              out_rd_addr;
    logic [XLEN-1:0]         out_rd_wdata;
    logic [3:0]              count;
    logic                    err_order;
    logic                    err_overflow;
    logic [ORDER_W-1:0]      exp_order;

    int n_pass;
    int n_total;

    rvfi_retire_serializer #(
        .NRET    (NRET),
        .XLEN    (XLEN),
        .DEPTH   (DEPTH),
        .ORDER_W (ORDER_W)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_order     (in_order),
        .in_insn      (in_insn),
        .in_trap      (in_trap),
        .in_pc_rdata  (in_pc_rdata),
        .in_pc_wdata  (in_pc_wdata),
        .in_rd_addr   (in_rd_addr),
        .in_rd_wdata  (in_rd_wdata),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_order    (out_order),
        .out_insn     (out_insn),
        .out_trap     (out_trap),
        .out_pc_rdata (out_pc_rdata),
        .out_pc_wdata (out_pc_wdata),
        .out_rd_addr  (out_rd_addr),
        .out_rd_wdata (out_rd_wdata),
        .count        (count),
        .err_order    (err_order),
        .err_overflow (err_overflow),
        .exp_order    (exp_order)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  iv;
        logic [63:0] o0;
        logic [63:0] o1;
        logic        ordy;
        logic        ov;
        logic [63:0] oord;
        logic [3:0]  cnt;
        logic        ir;
        logic        eo;
        logic        ef;
        logic [63:0] eord;
    } vec_t;

    vec_t vecs [14];

    // Payload fields are derived from the order so every field can be checked.
    function automatic logic [31:0] f_insn(input logic [63:0] o);
        return 32'hA500_0000 ^ o[31:0];
    endfunction
    function automatic logic [31:0] f_pcr(input logic [63:0] o);
        return {o[29:0], 2'b00};
    endfunction
    function automatic logic [31:0] f_pcw(input logic [63:0] o);
        return {o[29:0], 2'b00} + 32'd4;
    endfunction
    function automatic logic [31:0] f_rdw(input logic [63:0] o);
        return ~o[31:0];
    endfunction

    function automatic vec_t mk(input logic [1:0] iv, input logic [63:0] o0, input logic [63:0] o1,
                                input logic ordy, input logic ov, input logic [63:0] oord,
                                input logic [3:0] cnt, input logic ir, input logic eo,
                                input logic ef, input logic [63:0] eord);
        vec_t v;
        v.iv = iv; v.o0 = o0; v.o1 = o1; v.ordy = ordy; v.ov = ov; v.oord = oord;
        v.cnt = cnt; v.ir = ir; v.eo = eo; v.ef = ef; v.eord = eord;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic chk_head(input string tag, input logic ev, input logic [63:0] eo);
        chk({tag, ".out_valid"},    64'(out_valid),    64'(ev));
        chk({tag, ".out_order"},    out_order,         ev ? eo : 64'd0);
        chk({tag, ".out_insn"},     64'(out_insn),     ev ? 64'(f_insn(eo)) : 64'd0);
        chk({tag, ".out_trap"},     64'(out_trap),     ev ? 64'(eo[0]) : 64'd0);
        chk({tag, ".out_pc_rdata"}, 64'(out_pc_rdata), ev ? 64'(f_pcr(eo)) : 64'd0);
        chk({tag, ".out_pc_wdata"}, 64'(out_pc_wdata), ev ? 64'(f_pcw(eo)) : 64'd0);
        chk({tag, ".out_rd_addr"},  64'(out_rd_addr),  ev ? 64'(eo[4:0]) : 64'd0);
        chk({tag, ".out_rd_wdata"}, 64'(out_rd_wdata), ev ? 64'(f_rdw(eo)) : 64'd0);
    endtask

    task automatic chk_state(input string tag, input logic [3:0] cnt, input logic ir,
                             input logic eo, input logic ef, input logic [63:0] eord);
        chk({tag, ".count"},        64'(count),        64'(cnt));
        chk({tag, ".in_ready"},     64'(in_ready),     64'(ir));
        chk({tag, ".err_order"},    64'(err_order),    64'(eo));
        chk({tag, ".err_overflow"}, 64'(err_overflow), 64'(ef));
        chk({tag, ".exp_order"},    exp_order,         eord);
    endtask

    task automatic drive(input logic [1:0] iv, input logic [63:0] o0, input logic [63:0] o1);
        in_valid    = iv;
        in_order    = {o1, o0};
        in_insn     = {f_insn(o1), f_insn(o0)};
        in_trap     = {o1[0], o0[0]};
        in_pc_rdata = {f_pcr(o1), f_pcr(o0)};
        in_pc_wdata = {f_pcw(o1), f_pcw(o0)};
        in_rd_addr  = {o1[4:0], o0[4:0]};
        in_rd_wdata = {f_rdw(o1), f_rdw(o0)};
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nxt;
        int rx;
        int cyc;
        n_pass  = 0;
        n_total = 0;

        // iv, o0, o1, out_ready -> out_valid, out_order, count, in_ready, err_order, err_overflow, exp_order
        vecs[0]  = mk(2'b01,  0,  0, 1'b1,  1'b1, 0, 4'd1, 1'b1, 1'b0, 1'b0, 0);
        vecs[1]  = mk(2'b00,  0,  0, 1'b1,  1'b0, 0, 4'd0, 1'b1, 1'b0, 1'b0, 1);
        vecs[2]  = mk(2'b10, 99,  1, 1'b1,  1'b1, 1, 4'd1, 1'b1, 1'b0, 1'b0, 1);
        vecs[3]  = mk(2'b11,  2,  3, 1'b1,  1'b1, 2, 4'd2, 1'b1, 1'b0, 1'b0, 2);
        vecs[4]  = mk(2'b00,  0,  0, 1'b1,  1'b1, 3, 4'd1, 1'b1, 1'b0, 1'b0, 3);
        vecs[5]  = mk(2'b00,  0,  0, 1'b1,  1'b0, 0, 4'd0, 1'b1, 1'b0, 1'b0, 4);
        vecs[6]  = mk(2'b11,  4,  5, 1'b0,  1'b1, 4, 4'd2, 1'b1, 1'b0, 1'b0, 4);
        vecs[7]  = mk(2'b11,  6,  7, 1'b0,  1'b1, 4, 4'd4, 1'b1, 1'b0, 1'b0, 4);
        vecs[8]  = mk(2'b11,  8,  9, 1'b0,  1'b1, 4, 4'd6, 1'b1, 1'b0, 1'b0, 4);
        vecs[9]  = mk(2'b11, 10, 11, 1'b0,  1'b1, 4, 4'd8, 1'b0, 1'b0, 1'b0, 4);
        vecs[10] = mk(2'b11, 12, 13, 1'b0,  1'b1, 4, 4'd8, 1'b0, 1'b0, 1'b1, 4);
        vecs[11] = mk(2'b00,  0,  0, 1'b1,  1'b1, 5, 4'd7, 1'b0, 1'b0, 1'b1, 5);
        vecs[12] = mk(2'b00,  0,  0, 1'b1,  1'b1, 6, 4'd6, 1'b1, 1'b0, 1'b1, 6);
        vecs[13] = mk(2'b11, 12, 13, 1'b1,  1'b1, 7, 4'd7, 1'b0, 1'b0, 1'b1, 7);

        reset_n   = 1'b0;
        out_ready = 1'b0;
        drive(2'b00, 0, 0);
        #3;
        chk_state("reset", 4'd0, 1'b1, 1'b0, 1'b0, 0);
        chk_head("reset", 1'b0, 0);
        #9 reset_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].o0, vecs[i].o1);
            out_ready = vecs[i].ordy;
            step();
            chk_state($sformatf("v%0d", i), vecs[i].cnt, vecs[i].ir, vecs[i].eo, vecs[i].ef, vecs[i].eord);
            chk_head($sformatf("v%0d", i), vecs[i].ov, vecs[i].oord);
        end

        // Drain the wrapped queue: orders 7..13 in sequence.
        drive(2'b00, 0, 0);
        out_ready = 1'b1;
        for (int o = 7; o <= 13; o++) begin
            chk_head($sformatf("drain%0d", o), 1'b1, 64'(o));
            step();
        end
        chk_state("drained", 4'd0, 1'b1, 1'b0, 1'b1, 14);

        // Streaming push/pop of orders 0..19 with intermittent sink stalls.
        #2 reset_n = 1'b0;
        #2 reset_n = 1'b1;
        nxt = 0;
        rx  = 0;
        cyc = 0;
        while (rx < 20 && cyc < 300) begin
            if (in_ready && nxt < 20) begin
                if (nxt == 19) begin
                    drive(2'b01, 64'(nxt), 0);
                    nxt += 1;
                end else begin
                    drive(2'b11, 64'(nxt), 64'(nxt + 1));
                    nxt += 2;
                end
            end else begin
                drive(2'b00, 0, 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if (out_valid && out_ready) begin
                chk($sformatf("stream%0d.out_order", rx), out_order, 64'(rx));
                rx++;
            end
            step();
            cyc++;
        end
        drive(2'b00, 0, 0);
        chk("stream.received", 64'(rx), 64'd20);
        chk_state("stream.end", 4'd0, 1'b1, 1'b0, 1'b0, 20);

        // Order gap: 0,1,3,4.
        #2 reset_n = 1'b0;
        #2 reset_n = 1'b1;
        out_ready = 1'b1;
        drive(2'b11, 0, 1);
        step();
        chk_head("gap0", 1'b1, 0);
        drive(2'b01, 3, 0);
        step();
        chk_state("gap1", 4'd2, 1'b1, 1'b0, 1'b0, 1);
        drive(2'b01, 4, 0);
        step();
        chk_state("gap2", 4'd2, 1'b1, 1'b0, 1'b0, 2);
        chk_head("gap2", 1'b1, 3);
        drive(2'b00, 0, 0);
        step();
        chk_state("gap3", 4'd1, 1'b1, 1'b1, 1'b0, 4);
        chk_head("gap3", 1'b1, 4);
        step();
        chk_state("gap4", 4'd0, 1'b1, 1'b1, 1'b0, 5);

        // Async reset with five entries queued and a sticky error set.
        out_ready = 1'b0;
        drive(2'b11, 5, 6);
        step();
        drive(2'b11, 7, 8);
        step();
        drive(2'b01, 9, 0);
        step();
        drive(2'b00, 0, 0);
        chk_state("prerst", 4'd5, 1'b1, 1'b1, 1'b0, 5);
        chk_head("prerst", 1'b1, 5);
        #2 reset_n = 1'b0;
        #1;
        chk_state("asyncrst", 4'd0, 1'b1, 1'b0, 1'b0, 0);
        chk_head("asyncrst", 1'b0, 0);
        #2 reset_n = 1'b1;

        // Pointers restart at slot 0 after reset.
        out_ready = 1'b1;
        drive(2'b01, 0, 0);
        step();
        drive(2'b00, 0, 0);
        chk_head("postrst", 1'b1, 0);
        step();
        chk_state("postrst.end", 4'd0, 1'b1, 1'b0, 1'b0, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rvfi_retire_serializer.md
Name: rvfi_retire_serializer

Overview:
- Sits between a multi-retire hart's RVFI ports and the formal/trace harness.
- Accepts up to NRET retirement packets per cycle into a DEPTH-entry FIFO and replays them one per cycle on a single RVFI channel with valid/ready backpressure.
- Checks that rvfi_order is contiguous and raises sticky error flags for order gaps and overflow.
- Generalises the single-channel hart hookup to NRET channels, adds buffering, and adds stream checking.

Parameters:
- NRET, 2: retirement channels per cycle (1..4).
- XLEN, 32: data/pc width.
- DEPTH, 8: FIFO entries; power of two, DEPTH >= NRET.
- ORDER_W, 64: rvfi_order width.

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  NRET  per-channel rvfi_valid.
- in_order  in  NRET*ORDER_W  per-channel order; channel k at slice k.
- in_insn  in  NRET*32  per-channel insn.
- in_trap  in  NRET  per-channel trap.
- in_pc_rdata  in  NRET*XLEN  per-channel pc before the instruction.
- in_pc_wdata  in  NRET*XLEN  per-channel pc after the instruction.
- in_rd_addr  in  NRET*5  per-channel rd address.
- in_rd_wdata  in  NRET*XLEN  per-channel rd write data.
- in_ready  out  1  high when at least NRET slots are free.
- out_valid  out  1  head packet valid.
- out_ready  in  1  sink accepts the head packet.
- out_order, out_insn, out_trap, out_pc_rdata, out_pc_wdata, out_rd_addr, out_rd_wdata  out  per-field widths  head packet fields.
- count  out  $clog2(DEPTH)+1  occupied entries.
- err_order  out  1  sticky: dequeued order differed from the expected order.
- err_overflow  out  1  sticky: any in_valid bit high while in_ready low.
- exp_order  out  ORDER_W  next expected order.

Behaviour:
- Reset (asynchronous, reset_n low):
  - count=0, out_valid=0, all out_* fields 0.
  - err_order=0, err_overflow=0, exp_order=0.
  - Read and write pointers 0; in_ready=1.
  - Reset mid-operation discards all entries immediately.
- Enqueue:
  - in_ready = (DEPTH - count >= NRET), computed from the registered count only; no same-cycle dequeue credit.
  - When in_ready=1, every channel with in_valid=1 is written in ascending channel index, compacted to consecutive slots at wptr, wptr+1, ...
  - Gaps in in_valid (e.g. 2'b10) are legal; only set bits are enqueued.
  - wptr advances by popcount(in_valid), modulo DEPTH.
- Overflow:
  - If in_ready=0 and any in_valid bit is set, nothing is written and err_overflow sets.
- Dequeue:
  - out_valid = (count != 0); out_* is driven combinationally from the entry at rptr.
  - A transfer occurs when out_valid && out_ready; rptr increments modulo DEPTH.
  - out_* stays stable while out_valid && !out_ready.
- Latency: a packet enqueued at edge N is visible on out_* after edge N, i.e. one cycle from in_valid to out_valid when the FIFO was empty.
- Count: count_next = count + popcount(accepted in_valid) - transfer. Simultaneous enqueue and dequeue is legal; count never exceeds DEPTH.
- Pointer wrap: plain modulo-DEPTH increment; full/empty is derived from count, never from pointer equality.
- Order check, on each transfer:
  - If out_order != exp_order, err_order sets.
  - exp_order <= out_order + 1 in all cases, so it resynchronises after a gap.
  - exp_order wraps modulo 2^ORDER_W.
- Sticky errors clear only on reset.
- No assertion on in_* when in_valid is low; those field values are ignored.

Decomposition:
- Package rvfi_pkg holds:
  - typedef rvfi_pkt_t, a packed struct of order, insn, trap, pc_rdata, pc_wdata, rd_addr, rd_wdata, parametrised via package localparams for XLEN and ORDER_W;
  - localparam RVFI_NRET_MAX=4;
  - a popcount function.
- Sub-module rvfi_pkt_ram: DEPTH x rvfi_pkt_t register array.
  - NRET write ports with per-port enable and address.
  - One asynchronous read port.
  - Reset only on pointers and flags, not on array contents.
- Channel compaction (prefix-popcount to slot offset) stays in the top level.

Test Plan:
- Single retire: NRET=2, in_valid=2'b01 with order 0, out_ready=1 -> out_valid=1 the next cycle with out_order=0; count returns to 0; err_order=0.
- Dual retire with compaction: in_valid=2'b10 with ch1 order=0, then 2'b11 with orders 1,2 -> outputs order 0,1,2 on three consecutive cycles; exp_order=3.
- Backpressure and full: DEPTH=8, out_ready=0, four cycles of 2'b11 -> count=8, in_ready=0; a fifth push sets err_overflow=1 and count stays 8; out_order stays stable.
- Simultaneous push/pop at count=6: in_ready=1, 2'b11 pushed while out_ready=1 -> count=7 next cycle; pointers wrap past 7->0 correctly over 20 packets in order 0..19.
- Order gap: dequeue orders 0,1,3 -> err_order sets after the third transfer and exp_order=4; a following order 4 raises no new mismatch and err_order stays 1.
- Async reset mid-stream: reset_n low between edges with count=5 -> count=0, out_valid=0, errors cleared, exp_order=0 immediately without waiting for a clock edge.
